// File: rtl/vx_dispatch_pkg.sv
// Shared configuration, state encoding and packet-header type for the dispatch serializer.
// The warp/lane geometry is set here and imported by every block of the serializer.
package vx_dispatch_pkg;

  localparam int NUM_THREADS = 8;
  localparam int NUM_LANES   = 2;
  localparam int XLEN        = 32;
  localparam int NUM_SRC     = 3;
  localparam int META_W      = 64;

  function automatic int calc_num_pkts(input int threads, input int lanes);
    return threads / lanes;
  endfunction

  function automatic int calc_pid_width(input int pkts);
    return (pkts > 1) ? $clog2(pkts) : 1;
  endfunction

  localparam int NUM_PKTS  = calc_num_pkts(NUM_THREADS, NUM_LANES);
  localparam int PID_WIDTH = calc_pid_width(NUM_PKTS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [META_W-1:0]    meta;
    logic [NUM_LANES-1:0] tmask;
    logic [PID_WIDTH-1:0] pid;
    logic                 sop;
    logic                 eop;
  } pkt_hdr_t;

endpackage

// File: rtl/vx_lane_group_finder.sv
// Combinational priority finder over lane-group valid bits: lowest valid group,
// and the lowest valid group strictly above cur_pid_i.
module vx_lane_group_finder
  import vx_dispatch_pkg::*;
(
  input  logic [NUM_PKTS-1:0]  grp_valid_i,
  input  logic [PID_WIDTH-1:0] cur_pid_i,
  output logic [PID_WIDTH-1:0] first_pid_o,
  output logic [PID_WIDTH-1:0] next_pid_o,
  output logic                 has_next_o
);

  always_comb begin
    first_pid_o = '0;
    next_pid_o  = '0;
    has_next_o  = 1'b0;
    // NOTE: blocking '=' here: later iterations overwrite earlier ones, so the descending scan keeps the lowest match.
    for (int i = NUM_PKTS - 1; i >= 0; i--) begin
      if (grp_valid_i[i]) begin
        first_pid_o = PID_WIDTH'(i);
      end
      if (grp_valid_i[i] && (i > int'(cur_pid_i))) begin
        next_pid_o = PID_WIDTH'(i);
        has_next_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_dispatch_serializer.sv
// Serialises one full-warp dispatch into NUM_PKTS lane-group packets with pid/sop/eop.
// Define DISPATCH_LANE_SKIP_EN to skip lane groups whose thread-mask slice is empty.
module vx_dispatch_serializer
  import vx_dispatch_pkg::*;
(
  input  logic                                 clk_i,
  input  logic                                 reset_ni,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [META_W-1:0]                    in_meta_i,
  input  logic [NUM_THREADS-1:0]               in_tmask_i,
  input  logic [NUM_THREADS*NUM_SRC*XLEN-1:0]  in_rs_data_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [META_W-1:0]                    out_meta_o,
  output logic [NUM_LANES-1:0]                 out_tmask_o,
  output logic [NUM_LANES*NUM_SRC*XLEN-1:0]    out_rs_data_o,
  output logic [PID_WIDTH-1:0]                 out_pid_o,
  output logic                                 out_sop_o,
  output logic                                 out_eop_o
);

  localparam int GRP_W = NUM_LANES * NUM_SRC * XLEN;
  localparam int RS_W  = NUM_THREADS * NUM_SRC * XLEN;

  state_e                 state_q, state_d;
  logic [META_W-1:0]      meta_q, meta_d;
  logic [NUM_THREADS-1:0] tmask_q, tmask_d;
  logic [RS_W-1:0]        rs_q, rs_d;
  logic [PID_WIDTH-1:0]   pid_q, pid_d;
  logic                   sop_q, sop_d;

  logic                   eop;
  logic                   fire;
  logic                   accept;
  logic                   in_ready;
  logic [PID_WIDTH-1:0]   first_pid;
  logic [PID_WIDTH-1:0]   next_pid;
  pkt_hdr_t               hdr;

`ifdef DISPATCH_LANE_SKIP_EN
  logic [NUM_PKTS-1:0]  in_grp_vld;
  logic [NUM_PKTS-1:0]  held_grp_vld;
  logic                 has_next;
  logic [PID_WIDTH-1:0] in_next_unused;
  logic                 in_has_next_unused;
  logic [PID_WIDTH-1:0] held_first_unused;

  for (genvar g = 0; g < NUM_PKTS; g++) begin : g_grp_vld
    assign in_grp_vld[g]   = |in_tmask_i[g*NUM_LANES +: NUM_LANES];
    assign held_grp_vld[g] = |tmask_q[g*NUM_LANES +: NUM_LANES];
  end

  // Start point is taken from the incoming mask, the advance from the held one.
  vx_lane_group_finder u_first_finder (
    .grp_valid_i (in_grp_vld),
    .cur_pid_i   ('0),
    .first_pid_o (first_pid),
    .next_pid_o  (in_next_unused),
    .has_next_o  (in_has_next_unused)
  );

  vx_lane_group_finder u_next_finder (
    .grp_valid_i (held_grp_vld),
    .cur_pid_i   (pid_q),
    .first_pid_o (held_first_unused),
    .next_pid_o  (next_pid),
    .has_next_o  (has_next)
  );

  assign eop = ~has_next;
`else
  assign first_pid = '0;
  assign next_pid  = pid_q + PID_WIDTH'(1);
  // An all-zero mask still produces a single terminating packet at pid 0.
  assign eop       = (pid_q == PID_WIDTH'(NUM_PKTS - 1)) | ~(|tmask_q);
`endif

  always_comb begin
    // NOTE: every next-state target gets its default first, so no path can infer a latch.
    state_d  = state_q;
    meta_d   = meta_q;
    tmask_d  = tmask_q;
    rs_d     = rs_q;
    pid_d    = pid_q;
    sop_d    = sop_q;

    fire     = (state_q == ST_SEND) & out_ready_i;
    in_ready = (state_q == ST_IDLE) | (fire & eop);
    accept   = in_valid_i & in_ready;

    if (accept) begin
      state_d = ST_SEND;
      meta_d  = in_meta_i;
      tmask_d = in_tmask_i;
      rs_d    = in_rs_data_i;
      pid_d   = first_pid;
      sop_d   = 1'b1;
    end else if (fire) begin
      if (eop) begin
        state_d = ST_IDLE;
      end else begin
        pid_d = next_pid;
        sop_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      meta_q  <= '0;
      tmask_q <= '0;
      // NOTE: the operand store is reset too, because its zeroed contents are visible on out_rs_data after reset.
      rs_q    <= '0;
      pid_q   <= '0;
      sop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
      tmask_q <= tmask_d;
      rs_q    <= rs_d;
      pid_q   <= pid_d;
      sop_q   <= sop_d;
    end
  end

  assign out_valid_o = (state_q == ST_SEND);
  assign in_ready_o  = in_ready;

  assign hdr = '{
    meta:  meta_q,
    tmask: tmask_q[pid_q*NUM_LANES +: NUM_LANES],
    pid:   pid_q,
    sop:   sop_q & out_valid_o,
    eop:   eop & out_valid_o
  };

  assign out_meta_o    = hdr.meta;
  assign out_tmask_o   = hdr.tmask;
  assign out_pid_o     = hdr.pid;
  assign out_sop_o     = hdr.sop;
  assign out_eop_o     = hdr.eop;
  assign out_rs_data_o = rs_q[pid_q*GRP_W +: GRP_W];

endmodule

// File: doc/vx_dispatch_serializer.md
# vx_dispatch_serializer

Upstream neighbour of the ALU execute blocks: accepts one full-warp dispatch (NUM_THREADS lanes of source operands plus metadata) and serialises it into NUM_THREADS/NUM_LANES lane-group packets for a NUM_LANES-wide execute block. Each packet carries a packet index (pid) plus start-of-packet/end-of-packet flags, so the downstream commit gather can reassemble the warp. Used whenever an execute block is narrower than the warp.

## Interface
- NUM_THREADS, 8, warp width in lanes; power of 2
- NUM_LANES, 2, execute-block width; power of 2, at most NUM_THREADS
- XLEN, 32, operand width
- NUM_SRC, 3, source operands per lane
- META_W, 64, opaque per-warp metadata (uuid, wid, PC, rd, op args), passed through unchanged
- Derived: NUM_PKTS = NUM_THREADS/NUM_LANES; PID_WIDTH = max(1, clog2(NUM_PKTS))
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- in_valid  in  1  warp dispatch valid
- in_ready  out  1  warp accepted when in_valid & in_ready
- in_meta  in  META_W  warp metadata
- in_tmask  in  NUM_THREADS  thread mask
- in_rs_data  in  NUM_THREADS*NUM_SRC*XLEN  operands; lane t, source s at bits ((t*NUM_SRC+s)*XLEN) and up
- out_valid  out  1  packet valid
- out_ready  in  1  packet consumed when out_valid & out_ready
- out_meta  out  META_W  copy of captured in_meta
- out_tmask  out  NUM_LANES  in_tmask bits [pid*NUM_LANES +: NUM_LANES]
- out_rs_data  out  NUM_LANES*NUM_SRC*XLEN  operands of lane group pid, same packing as input
- out_pid  out  PID_WIDTH  lane-group index
- out_sop  out  1  first packet of warp
- out_eop  out  1  last packet of warp

## Operation
- FSM states: IDLE (no warp held) and SEND (warp held, packet at out_pid presented).
- IDLE: in_ready=1. On accept, capture meta/tmask/rs_data, set pid to the first group, sop=1, go to SEND.
- SEND: out_valid=1. On out_ready with eop=0, advance pid to the next group, sop=0. On out_ready with eop=1, go to IDLE unless a new warp is accepted in the same cycle, in which case recapture and stay in SEND.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_eop); this is a combinational path from out_ready.
- Output payload and flags hold stable while out_valid & ~out_ready.
- NUM_LANES==NUM_THREADS: a single packet is emitted with pid=0 and sop=eop=1.
- All-zero in_tmask: a single packet is emitted with pid=0, sop=eop=1, out_tmask=0, so the downstream commit still fires.
- pid never wraps within a warp; eop is asserted exactly once per warp.

## Timing
- Latency is 1 cycle: out_valid rises the cycle after input accept.
- Throughput is one packet per cycle. Back-to-back warps produce no bubble; the first packet of warp N+1 follows the eop of warp N on the next cycle.
- Reset values: state=IDLE, out_valid=0, out_pid=0, out_sop=0, out_eop=0, out_meta=0, out_tmask=0, out_rs_data=0. in_ready=1 once reset is deasserted.
- Reset asserted mid-warp drops the held warp and emits no further packets for it.

## Configuration
- DISPATCH_LANE_SKIP_EN defined: lane groups whose tmask slice is zero are skipped.
  - pid starts at the lowest non-empty group and advances to the next non-empty group.
  - eop is set on the highest non-empty group.
  - The all-zero mask case still emits one packet at pid 0.
- DISPATCH_LANE_SKIP_EN undefined: all NUM_PKTS groups are emitted in order 0..NUM_PKTS-1, including empty ones.
  - eop is set at pid = NUM_PKTS-1.

## Structure
- Shared package vx_dispatch_pkg holds:
  - NUM_PKTS/PID_WIDTH derivation function
  - FSM state enum
  - packed struct of packet header {meta, tmask, pid, sop, eop}
- Sub-module vx_lane_group_finder: combinational priority finder.
  - Input: group-valid vector (OR of each tmask slice) and current pid.
  - Outputs: first group, next group after pid, and has_next.
  - Instantiated only under DISPATCH_LANE_SKIP_EN.

## Test plan
- Reset, then warp accept with NUM_THREADS=8, NUM_LANES=2, tmask=0xFF, out_ready=1 -> packets pid 0,1,2,3 on consecutive cycles; sop only on pid0, eop only on pid3; out_rs_data of pid2 = lanes 4,5.
- Back pressure: out_ready low for 3 cycles at pid1 -> out_pid/out_tmask/out_rs_data held unchanged; in_ready=0 throughout; resumes with pid2.
- Two warps back-to-back with in_valid held high -> second warp's pid0 (sop=1) appears the cycle after first warp's eop; exactly 8 packets in 8 cycles.
- tmask=0x30 with DISPATCH_LANE_SKIP_EN -> single packet pid2, sop=eop=1, out_tmask=0b11; without the macro -> 4 packets, pid2 out_tmask=0b11, others 0, eop at pid3.
- tmask=0x00 -> one packet pid0, sop=eop=1, out_tmask=0, in both configurations.
- reset low during pid1 -> next cycle out_valid=0 and all outputs 0; after release, a new warp starts cleanly at sop.
